// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB stage vs buffered multi-cycle results.
// WB normally wins; a starved FIFO head steals the port for one cycle.
module rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        wb_werf,
    input  logic [4:0]  wb_wa,
    input  logic [31:0] wb_wd,
    input  logic        mc_valid,
    input  logic [4:0]  mc_wa,
    input  logic [31:0] mc_wd,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        wb_stall,
    output logic [31:0] pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, STEAL} state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]      wa_q [DEPTH];
    logic [4:0]      wa_d [DEPTH];
    logic [31:0]     wd_q [DEPTH];
    logic [31:0]     wd_d [DEPTH];
    logic [PW-1:0]   hd_q, hd_d, tl_q, tl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     pend_q, pend_d;

    logic        hd_any, hd_v, wb_ok, push, pop;
    logic        g_we;
    logic [4:0]  g_wa;
    logic [31:0] g_wd;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Port grant, kill/pop/push bookkeeping, starvation and next state.
    always_comb begin
        mc_ready = (cnt_q < CW'(DEPTH));
        hd_any   = (cnt_q != '0);
        hd_v     = hd_any && vld_q[hd_q];
        wb_ok    = wb_werf && (wb_wa != 5'd31) && (state_q != STEAL);
        push     = mc_valid && mc_ready && (mc_wa != 5'd31);
        pop      = 1'b0;
        g_we     = 1'b0;
        g_wa     = '0;
        g_wd     = '0;

        if (state_q == STEAL) begin
            pop = hd_any;
            if (hd_v) begin
                g_we = 1'b1;
                g_wa = wa_q[hd_q];
                g_wd = wd_q[hd_q];
            end
        end else if (wb_ok) begin
            g_we = 1'b1;
            g_wa = wb_wa;
            g_wd = wb_wd;
            pop  = hd_any && !hd_v;
        end else if (hd_any) begin
            pop = 1'b1;
            if (hd_v) begin
                g_we = 1'b1;
                g_wa = wa_q[hd_q];
                g_wd = wd_q[hd_q];
            end
        end

        vld_d = vld_q;
        wa_d  = wa_q;
        wd_d  = wd_q;
        hd_d  = hd_q;
        tl_d  = tl_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_ok && (wa_q[i] == wb_wa)) vld_d[i] = 1'b0;
        end
        if (pop) begin
            vld_d[hd_q] = 1'b0;
            hd_d        = inc(hd_q);
        end
        if (push) begin
            vld_d[tl_q] = 1'b1;
            wa_d[tl_q]  = mc_wa;
            wd_d[tl_q]  = mc_wd;
        end
        if (mc_valid && mc_ready) tl_d = push ? inc(tl_q) : tl_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        starve_d = (hd_v && !pop) ? starve_q + SW'(1) : '0;

        if ((state_q != STEAL) && (starve_d >= SW'(STARVE_LIMIT)))
            state_d = STEAL;
        else if (cnt_d != '0)
            state_d = DRAIN;
        else
            state_d = IDLE;

        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_d[i]) pend_d[wa_d[i]] = 1'b1;
        end
    end

    // Drive the write port; forced quiet while reset is held.
    always_comb begin
        rf_we     = g_we && n_rst;
        rf_wa     = rf_we ? g_wa : 5'd0;
        rf_wd     = rf_we ? g_wd : 32'd0;
        wb_stall  = (state_q == STEAL);
        pend_mask = pend_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            hd_q     <= '0;
            tl_q     <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i] <= '0;
                wd_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            hd_q     <= hd_d;
            tl_q     <= tl_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i] <= wa_d[i];
                wd_q[i] <= wd_d[i];
            end
        end
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4; consecutive cycles the FIFO head may be denied the port before a steal.
REQ-002 Parameter: DEPTH, default 2; number of multi-cycle result buffer entries.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 n_rst  in  1  reset; asynchronous, active-low.
REQ-005 wb_werf  in  1  pipeline WB stage requests a register-file write.
REQ-006 wb_wa  in  5  WB destination register.
REQ-007 wb_wd  in  32  WB write data.
REQ-008 mc_valid  in  1  multi-cycle unit offers a result.
REQ-009 mc_wa  in  5  multi-cycle destination register.
REQ-010 mc_wd  in  32  multi-cycle result data.
REQ-011 mc_ready  out  1  result accepted this cycle when mc_valid=1.
REQ-012 rf_we  out  1  register-file write enable.
REQ-013 rf_wa  out  5  register-file write address.
REQ-014 rf_wd  out  32  register-file write data.
REQ-015 wb_stall  out  1  registered; WB stage must hold its instruction; WB inputs ignored this cycle.
REQ-016 pend_mask  out  32  bit r set iff a valid FIFO entry targets register r.

Function
REQ-017 FIFO: DEPTH entries, each holding valid bit, wa, and wd; push at tail, pop at head; pointers wrap modulo DEPTH.
REQ-018 mc_ready = (count < DEPTH), from registered count only; no combinational path from mc_valid.
REQ-019 Push when mc_valid & mc_ready; mc_wa=31 is handshaken (mc_ready honoured) but discarded, not pushed.
REQ-020 States: IDLE (count=0), DRAIN (count>0, no steal), STEAL (wb_stall=1).
REQ-021 Port priority, IDLE/DRAIN: WB write with wb_werf=1 and wb_wa!=31 wins; else a valid head is written and popped.
REQ-022 STEAL: valid head written and popped regardless of wb_werf; WB inputs ignored.
REQ-023 Invalid (killed) head: popped in one cycle without rf_we; WB may use the port that cycle.
REQ-024 rf_we=0 when no write is granted; rf_wa and rf_wd are then 0.
REQ-025 Outputs rf_we/rf_wa/rf_wd are combinational from WB inputs, FIFO head, and state; no added latency for WB.
REQ-026 Minimum FIFO latency: entry pushed in cycle N reaches rf_we no earlier than cycle N+1; no same-cycle bypass.
REQ-027 Starve counter: increments each cycle a valid head is present but not written; cleared on any pop and in IDLE.
REQ-028 When starve counter reaches STARVE_LIMIT, go to STEAL next cycle; STEAL lasts exactly one cycle; then DRAIN if count>0, else IDLE.
REQ-029 Kill: a granted WB write to register r clears the valid bit of every FIFO entry with wa=r.
REQ-030 An entry pushed in the same cycle as a matching WB write is not killed.
REQ-031 Simultaneous push and pop: count unchanged; a push is always permitted when count<DEPTH before the pop.
REQ-032 pend_mask: registered, recomputed from valid entries after each push/pop/kill.
REQ-033 Register 31 never written: rf_we never asserts with rf_wa=31.
REQ-034 Empty FIFO with no WB write: rf_we=0; starve counter holds at 0.

Reset
REQ-035 n_rst=0 asynchronously: FIFO empty, all valid bits 0, pointers 0, starve counter 0, state IDLE.
REQ-036 Outputs during/after reset: wb_stall=0, pend_mask=0, mc_ready=1, rf_we=0.
REQ-037 Reset mid-operation discards buffered results without writing them; first post-reset cycle behaves as IDLE.

Verification
REQ-038 Bypass: WB writes r5=0x11 with FIFO empty -> same-cycle rf_we=1, rf_wa=5, rf_wd=0x11; wb_stall stays 0.
REQ-039 Drain: push r3=0xAB, WB idle -> next cycle rf_we=1, rf_wa=3, rf_wd=0xAB; pend_mask bit3 1 then 0.
REQ-040 Starvation: push r7=0x7, wb_werf=1 every cycle with r1 -> wb_stall=1 in cycle 5 (limit 4), r7 written that cycle, r1 written cycle 6.
REQ-041 Full: two pushes, WB busy -> mc_ready=0; third mc_valid held until a pop, then accepted.
REQ-042 Kill: FIFO holds r9=0x1; WB writes r9=0x2 -> entry dropped, r9 never written with 0x1, pend_mask bit9 cleared.
REQ-043 Reset: n_rst low with 2 entries queued -> immediately mc_ready=1, pend_mask=0, no rf_we for old entries after release.
